// File: rtl/flash_timer_gen.sv
// Retriggerable one-shot/periodic interval timer producing registered done pulses.
// Optional tick prescaler enabled by defining FLASH_TIMER_PRESCALE_EN.
`timescale 1ns/1ps
module flash_timer_gen #(
  parameter int CNT_W    = 26,
  parameter int PRESCALE = 50000
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {IDLE, COUNTING} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("flash_timer_gen: PRESCALE must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             step;

`ifdef FLASH_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;

  assign step = (pre_q == PW'(PRESCALE - 1));

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`else
  assign step = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    done_d      = 1'b0;
`ifdef FLASH_TIMER_PRESCALE_EN
    pre_d       = pre_q;
`endif
    if (stop) begin
      state_d     = IDLE;
      remaining_d = '0;
`ifdef FLASH_TIMER_PRESCALE_EN
      pre_d       = '0;
`endif
    end else if (start) begin
      // A zero load is treated as the shortest interval rather than "never".
      reload_d    = (load == '0) ? ONE : load;
      remaining_d = (load == '0) ? ONE : load;
      periodic_d  = periodic;
      state_d     = COUNTING;
`ifdef FLASH_TIMER_PRESCALE_EN
      pre_d       = '0;
`endif
    end else if (state_q == COUNTING) begin
`ifdef FLASH_TIMER_PRESCALE_EN
      pre_d = step ? '0 : pre_q + PW'(1);
`endif
      if (step) begin
        if (remaining_q > ONE) begin
          remaining_d = remaining_q - ONE;
        end else begin
          done_d = 1'b1;
          if (periodic_q) begin
            remaining_d = reload_q;
          end else begin
            remaining_d = '0;
            state_d     = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == COUNTING);
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule
